// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - FP32 field widths, unpacked-operand type and special-class bit indices
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;
  localparam int BIAS   = 127;

  // Bit positions inside the 3-bit special class {is_nan, is_inf, is_zero}
  localparam int SPC_NAN  = 2;
  localparam int SPC_INF  = 1;
  localparam int SPC_ZERO = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic              hidden;
    logic [FRAC_W-1:0] frac;
  } fp_unpacked_t;

  // Split a binary32 word into fields; the hidden bit is set for any nonzero exponent
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign   = x[31];
    u.exp    = x[30:23];
    u.hidden = (x[30:23] != '0);
    u.frac   = x[22:0];
    return u;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// rtl/fp_align_shifter.sv - combinational 27-bit right shifter with sticky collection
module fp_align_shifter
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] din,
  input  logic [7:0]        shamt,
  output logic [MANT_W-1:0] dout
);

  logic [MANT_W-1:0] lost;

  // Shift right; any 1 shifted past bit 0 is ORed into the sticky (LSB) position
  always_comb begin
    dout = '0;
    lost = '0;
    if (shamt >= 8'(MANT_W)) begin
      dout = {{(MANT_W-1){1'b0}}, |din};
    end else begin
      dout    = din >> shamt;
      lost    = din & ~({MANT_W{1'b1}} << shamt);
      dout[0] = dout[0] | (|lost);
    end
  end

endmodule

// File: rtl/fp_align_adder.sv
// rtl/fp_align_adder.sv - FP32 pre-normalization align/add stage; optional FP_SPECIAL_EN adds operand classification
module fp_align_adder #(
  parameter int WIDTH  = 32,
  parameter int MANT_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] result_mant,
  output logic [7:0]        exp_result,
  output logic              carry_out,
  output logic              result_sign,
  output logic              a_sign,
  output logic              b_sign,
  output logic              op_out,
  output logic [2:0]        special
);

  import fp_pkg::*;

  // ---------------- S1: unpack / compare ----------------
  fp_unpacked_t ua, ub;
  logic         sb, eff_sub, a_ge_b, sign_l;
  logic [23:0]  l_sig, s_sig;
  logic [7:0]   l_exp, s_exp, l_exp_eff, s_exp_eff;
  logic [2:0]   spc;

`ifdef FP_SPECIAL_EN
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
`endif

  // Order operands by magnitude and form the alignment distance
  always_comb begin
    ua        = fp_unpack(a);
    ub        = fp_unpack(b);
    sb        = ub.sign ^ op;
    eff_sub   = ua.sign ^ sb;
    a_ge_b    = {ua.exp, ua.frac} >= {ub.exp, ub.frac};
    l_sig     = a_ge_b ? {ua.hidden, ua.frac} : {ub.hidden, ub.frac};
    s_sig     = a_ge_b ? {ub.hidden, ub.frac} : {ua.hidden, ua.frac};
    l_exp     = a_ge_b ? ua.exp : ub.exp;
    s_exp     = a_ge_b ? ub.exp : ua.exp;
    sign_l    = a_ge_b ? ua.sign : sb;
    // Denormals behave as exponent 1 for alignment purposes
    l_exp_eff = l_sig[23] ? l_exp : 8'd1;
    s_exp_eff = s_sig[23] ? s_exp : 8'd1;
    spc       = '0;
`ifdef FP_SPECIAL_EN
    a_nan     = (ua.exp == '1) && (ua.frac != '0);
    b_nan     = (ub.exp == '1) && (ub.frac != '0);
    a_inf     = (ua.exp == '1) && (ua.frac == '0);
    b_inf     = (ub.exp == '1) && (ub.frac == '0);
    a_zero    = (ua.exp == '0) && (ua.frac == '0);
    b_zero    = (ub.exp == '0) && (ub.frac == '0);
    spc[SPC_NAN]  = a_nan | b_nan | (a_inf & b_inf & eff_sub);
    spc[SPC_INF]  = ~spc[SPC_NAN] & (a_inf | b_inf);
    spc[SPC_ZERO] = a_zero & b_zero;
`endif
  end

  logic        s1_v, s2_v, s2_en;
  logic [23:0] s1_l_sig, s1_s_sig;
  logic [7:0]  s1_l_exp, s1_d;
  logic        s1_eff_sub, s1_sign_l, s1_a_sign, s1_b_sign, s1_op;
  logic [2:0]  s1_special;

  assign s2_en    = !s2_v || out_ready;
  assign in_ready = !s1_v || s2_en;

  // S1 register: accepts a new beat whenever downstream can make room
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_l_sig   <= '0;
      s1_s_sig   <= '0;
      s1_l_exp   <= '0;
      s1_d       <= '0;
      s1_eff_sub <= 1'b0;
      s1_sign_l  <= 1'b0;
      s1_a_sign  <= 1'b0;
      s1_b_sign  <= 1'b0;
      s1_op      <= 1'b0;
      s1_special <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_l_sig   <= l_sig;
        s1_s_sig   <= s_sig;
        s1_l_exp   <= l_exp;
        s1_d       <= l_exp_eff - s_exp_eff;
        s1_eff_sub <= eff_sub;
        s1_sign_l  <= sign_l;
        s1_a_sign  <= ua.sign;
        s1_b_sign  <= ub.sign;
        s1_op      <= op;
        s1_special <= spc;
      end
    end
  end

  // ---------------- S2: align / add ----------------
  logic [MANT_W-1:0] s_aligned, l_mant, nxt_mant;
  logic [MANT_W:0]   sum;
  logic [7:0]        nxt_exp;
  logic              nxt_carry, nxt_sign;

  fp_align_shifter u_shift (
    .din   ({s1_s_sig, 3'b000}),
    .shamt (s1_d),
    .dout  (s_aligned)
  );

  // Add or subtract the aligned significands; the swap keeps subtraction non-negative
  always_comb begin
    l_mant    = {s1_l_sig, 3'b000};
    sum       = s1_eff_sub ? ({1'b0, l_mant} - {1'b0, s_aligned})
                           : ({1'b0, l_mant} + {1'b0, s_aligned});
    nxt_mant  = sum[MANT_W-1:0];
    nxt_carry = sum[MANT_W];
    nxt_exp   = s1_l_exp;
    // Exact cancellation yields +0 under round-to-nearest-even
    nxt_sign  = (s1_eff_sub && (sum == '0)) ? 1'b0 : s1_sign_l;
    if (s1_special[SPC_NAN] || s1_special[SPC_INF]) begin
      nxt_mant  = '0;
      nxt_exp   = 8'hFF;
      nxt_carry = 1'b0;
    end
  end

  // S2 register: holds the output beat while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v        <= 1'b0;
      result_mant <= '0;
      exp_result  <= '0;
      carry_out   <= 1'b0;
      result_sign <= 1'b0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      op_out      <= 1'b0;
      special     <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result_mant <= nxt_mant;
        exp_result  <= nxt_exp;
        carry_out   <= nxt_carry;
        result_sign <= nxt_sign;
        a_sign      <= s1_a_sign;
        b_sign      <= s1_b_sign;
        op_out      <= s1_op;
        special     <= s1_special;
      end
    end
  end

  assign out_valid = s2_v;

endmodule
